// File: rtl/instr_encoder_if.sv
// Command and instruction-stream handshake bundle for instr_encoder.
// slave  : the encoder side (consumes commands, produces words).
// master : the harness/controller side.
interface instr_encoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_funct;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs;
  logic [6:0] cmd_imm;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr_data;
  logic       instr_parity;

  modport slave (
    input  cmd_valid, cmd_op, cmd_funct, cmd_rd, cmd_rs, cmd_imm, instr_ready,
    output cmd_ready, instr_valid, instr_data, instr_parity
  );

  modport master (
    output cmd_valid, cmd_op, cmd_funct, cmd_rd, cmd_rs, cmd_imm, instr_ready,
    input  cmd_ready, instr_valid, instr_data, instr_parity
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs high-level commands into 9-bit instruction words,
// expands MOVE pseudo-ops, rejects illegal commands and streams words out
// through a small show-ahead FIFO. A DONE command drains the FIFO and halts.
// Optional macro INSTR_ENC_PARITY_EN: store/present even parity per word.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             halted
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [8:0]  DONE_WORD = 9'b010000000;

  localparam logic [2:0] OP_RTYPE  = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_ITYPE  = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_STORE  = 3'd4;
  localparam logic [2:0] OP_MOVE   = 3'd5;
  localparam logic [2:0] OP_DONE   = 3'd6;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] funct;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [6:0] imm;
  } cmd_t;

  cmd_t        cmd;
  state_t      state, state_nxt;
  logic        run_en;
  logic [8:0]  enc;
  logic        illegal, is_done;
  logic        full, cmd_fire, push, pop;
  logic [8:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [8:0]  head;

  assign cmd = {bus.cmd_op, bus.cmd_funct, bus.cmd_rd, bus.cmd_rs, bus.cmd_imm};

  // Field packing, MOVE expansion and illegal-command detection.
  always_comb begin
    enc     = '0;
    illegal = 1'b0;
    is_done = 1'b0;
    case (cmd.op)
      OP_RTYPE:  enc = {2'b00, cmd.funct, cmd.rd, cmd.rs};
      OP_BRANCH: begin
        enc     = {2'b01, cmd.imm};
        illegal = (cmd.imm == 7'd0);  // would alias the DONE word
      end
      OP_ITYPE:  enc = {2'b10, cmd.imm};
      OP_LOAD:   enc = {2'b11, 1'b0, cmd.imm[5:0]};
      OP_STORE:  enc = {2'b11, 1'b1, cmd.imm[5:0]};
      OP_MOVE: begin
        case ({cmd.rs, cmd.rd})
          4'b00_01: enc = 9'b000000100;
          4'b00_10: enc = 9'b000001000;
          4'b00_11: enc = 9'b000001100;
          4'b01_00: enc = 9'b000001001;
          4'b01_10: enc = 9'b000001101;
          4'b01_11: enc = 9'b000001110;
          4'b10_00: enc = 9'b000010100;
          4'b10_01: enc = 9'b000011000;
          4'b10_11: enc = 9'b000011100;
          4'b11_00: enc = 9'b000011001;
          4'b11_01: enc = 9'b000011101;
          4'b11_10: enc = 9'b000011110;
          default:  illegal = 1'b1;     // rd == rs
        endcase
      end
      OP_DONE: begin
        enc     = DONE_WORD;
        is_done = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // cmd_ready is held low for the reset cycle(s) and comes up one cycle later.
  always_ff @(posedge clk or posedge reset)
    if (reset) run_en <= 1'b0;
    else       run_en <= 1'b1;

  assign full            = (count == FULL_CNT);
  assign bus.cmd_ready   = run_en && (state == RUN) && !full;
  assign cmd_fire        = bus.cmd_valid && bus.cmd_ready;
  assign push            = cmd_fire && !illegal;
  assign head            = mem[rd_ptr];
  assign bus.instr_valid = (count != '0) && (state != HALTED);
  assign bus.instr_data  = bus.instr_valid ? head : '0;
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign halted          = (state == HALTED);

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= enc;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef INSTR_ENC_PARITY_EN
  logic par_mem [DEPTH];

  // Parity travels with its word through the FIFO.
  always_ff @(posedge clk)
    if (push) par_mem[wr_ptr] <= ^enc;

  assign bus.instr_parity = bus.instr_valid ? par_mem[rd_ptr] : 1'b0;
`else
  assign bus.instr_parity = 1'b0;
`endif

  // Error pulse and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= cmd_fire && illegal;
      if (cmd_fire && illegal && (err_count != '1))
        err_count <= err_count + ERR_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RUN;
    else       state <= state_nxt;

  // Next state: DONE word is always the last entry, so its departure ends DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cmd_fire && is_done) state_nxt = DRAIN;
      DRAIN:   if (pop && (head == DONE_WORD)) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, MOVE table, illegal handling,
// FIFO full/backpressure, DONE drain/halt, counter saturation, reset flush.
module tb_instr_encoder;
  logic       clk = 1'b0;
  logic       reset;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       halted;
  int         compared   = 0;
  int         mismatched = 0;

  instr_encoder_if bus_if();

  instr_encoder #(.DEPTH(4), .ERR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, then let it transfer.
  task automatic send(input logic [2:0] op, input logic [2:0] funct,
                      input logic [1:0] rd, input logic [1:0] rs,
                      input logic [6:0] imm);
    int n = 0;
    bus_if.cmd_op = op; bus_if.cmd_funct = funct;
    bus_if.cmd_rd = rd; bus_if.cmd_rs = rs; bus_if.cmd_imm = imm;
    bus_if.cmd_valid = 1'b1;
    while (!bus_if.cmd_ready && n < 50) begin tick(); n++; end
    compared++;
    if (!bus_if.cmd_ready) begin
      mismatched++;
      $display("FAIL send_timeout: cmd_ready=%0b required 1 (op=%0d)", bus_if.cmd_ready, op);
    end
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_op = '0; bus_if.cmd_funct = '0;
    bus_if.cmd_rd = '0; bus_if.cmd_rs = '0; bus_if.cmd_imm = '0;
    bus_if.instr_ready = 1'b1;
    tick(); tick();
    compared++;
    if ({bus_if.cmd_ready, bus_if.instr_valid, err_pulse, halted} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_outputs: ready/valid/pulse/halted=%b required 0000",
               {bus_if.cmd_ready, bus_if.instr_valid, err_pulse, halted});
    end
    compared++;
    if (err_count !== 8'd0) begin
      mismatched++; $display("FAIL reset_err_count: got %0d required 0", err_count);
    end
    reset = 1'b0;
    tick();
    compared++;
    if (bus_if.cmd_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_release_ready: got %b required 1", bus_if.cmd_ready);
    end
  endtask

  task automatic test_rtype();
    send(3'd0, 3'd1, 2'd2, 2'd1, 7'd0);
    compared++;
    if (bus_if.instr_valid !== 1'b1 || bus_if.instr_data !== 9'b000011001) begin
      mismatched++;
      $display("FAIL rtype_word: valid=%b data=%b required 1 000011001",
               bus_if.instr_valid, bus_if.instr_data);
    end
    compared++;
    if (err_count !== 8'd0) begin
      mismatched++; $display("FAIL rtype_err_count: got %0d required 0", err_count);
    end
    tick();
    compared++;
    if (bus_if.instr_valid !== 1'b0) begin
      mismatched++; $display("FAIL rtype_popped: valid=%b required 0", bus_if.instr_valid);
    end
  endtask

  task automatic test_move();
    send(3'd5, 3'd0, 2'd3, 2'd1, 7'd0);   // MOVE r1 -> r3
    compared++;
    if (bus_if.instr_data !== 9'b000001110) begin
      mismatched++; $display("FAIL move_1_3: got %b required 000001110", bus_if.instr_data);
    end
    send(3'd5, 3'd0, 2'd2, 2'd2, 7'd0);   // rd == rs: illegal, first word pops here
    compared++;
    if ({err_pulse, bus_if.instr_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL move_illegal: pulse/valid=%b required 10", {err_pulse, bus_if.instr_valid});
    end
    compared++;
    if (err_count !== 8'd1) begin
      mismatched++; $display("FAIL move_err_count: got %0d required 1", err_count);
    end
    tick();
    compared++;
    if (err_pulse !== 1'b0) begin
      mismatched++; $display("FAIL err_pulse_width: got %b required 0", err_pulse);
    end
  endtask

  task automatic test_fill();
    logic [8:0] exp [4];
    exp[0] = 9'b100000101; exp[1] = 9'b110000011;
    exp[2] = 9'b111000011; exp[3] = 9'b101111111;
    bus_if.instr_ready = 1'b0;
    send(3'd2, 3'd0, 2'd0, 2'd0, 7'd5);
    send(3'd3, 3'd0, 2'd0, 2'd0, 7'd3);
    send(3'd4, 3'd0, 2'd0, 2'd0, 7'd3);
    send(3'd2, 3'd0, 2'd0, 2'd0, 7'd127);
    compared++;
    if (bus_if.cmd_ready !== 1'b0) begin
      mismatched++; $display("FAIL full_ready: got %b required 0", bus_if.cmd_ready);
    end
    tick();
    compared++;
    if (bus_if.instr_valid !== 1'b1 || bus_if.instr_data !== exp[0]) begin
      mismatched++;
      $display("FAIL stall_stable: valid=%b data=%b required 1 %b",
               bus_if.instr_valid, bus_if.instr_data, exp[0]);
    end
    bus_if.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (bus_if.instr_valid !== 1'b1 || bus_if.instr_data !== exp[i]) begin
        mismatched++;
        $display("FAIL drain_%0d: valid=%b data=%b required 1 %b",
                 i, bus_if.instr_valid, bus_if.instr_data, exp[i]);
      end
      tick();
    end
    compared++;
    if (bus_if.instr_valid !== 1'b0) begin
      mismatched++; $display("FAIL drain_empty: valid=%b required 0", bus_if.instr_valid);
    end
  endtask

  task automatic test_back_to_back();
    send(3'd2, 3'd0, 2'd0, 2'd0, 7'd1);
    compared++;
    if (bus_if.instr_data !== 9'b100000001 || bus_if.instr_parity !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_first: data=%b par=%b required 100000001 0",
               bus_if.instr_data, bus_if.instr_parity);
    end
    send(3'd2, 3'd0, 2'd0, 2'd0, 7'd3);   // push and pop in the same cycle
`ifdef INSTR_ENC_PARITY_EN
    compared++;
    if (bus_if.instr_data !== 9'b100000011 || bus_if.instr_parity !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_second: data=%b par=%b required 100000011 1",
               bus_if.instr_data, bus_if.instr_parity);
    end
`else
    compared++;
    if (bus_if.instr_data !== 9'b100000011 || bus_if.instr_parity !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_second: data=%b par=%b required 100000011 0",
               bus_if.instr_data, bus_if.instr_parity);
    end
`endif
    tick();
    compared++;
    if (bus_if.instr_valid !== 1'b0) begin
      mismatched++; $display("FAIL b2b_empty: valid=%b required 0", bus_if.instr_valid);
    end
  endtask

  task automatic test_saturate();
    bus_if.cmd_op = 3'd7; bus_if.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    compared++;
    if (err_count !== 8'hFF || err_pulse !== 1'b1 || bus_if.instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL err_saturate: count=%0d pulse=%b valid=%b required 255 1 0",
               err_count, err_pulse, bus_if.instr_valid);
    end
    bus_if.cmd_valid = 1'b0;
    tick();
    compared++;
    if (err_count !== 8'hFF || err_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL err_hold: count=%0d pulse=%b required 255 0", err_count, err_pulse);
    end
  endtask

  task automatic test_done();
    send(3'd1, 3'd0, 2'd0, 2'd0, 7'd2);
    compared++;
    if (bus_if.instr_data !== 9'b010000010) begin
      mismatched++; $display("FAIL branch_word: got %b required 010000010", bus_if.instr_data);
    end
    send(3'd6, 3'd0, 2'd0, 2'd0, 7'd0);
    compared++;
    if (bus_if.instr_data !== 9'b010000000 || bus_if.cmd_ready !== 1'b0 || halted !== 1'b0) begin
      mismatched++;
      $display("FAIL done_word: data=%b ready=%b halted=%b required 010000000 0 0",
               bus_if.instr_data, bus_if.cmd_ready, halted);
    end
    bus_if.cmd_op = 3'd0; bus_if.cmd_funct = 3'd1; bus_if.cmd_valid = 1'b1;
    tick();
    compared++;
    if ({halted, bus_if.instr_valid, bus_if.cmd_ready} !== 3'b100) begin
      mismatched++;
      $display("FAIL halted_state: halted/valid/ready=%b required 100",
               {halted, bus_if.instr_valid, bus_if.cmd_ready});
    end
    for (int i = 0; i < 5; i++) tick();
    compared++;
    if ({halted, bus_if.instr_valid, bus_if.cmd_ready} !== 3'b100) begin
      mismatched++;
      $display("FAIL halted_hold: halted/valid/ready=%b required 100",
               {halted, bus_if.instr_valid, bus_if.cmd_ready});
    end
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    bus_if.instr_ready = 1'b0;
    send(3'd2, 3'd0, 2'd0, 2'd0, 7'd9);
    send(3'd2, 3'd0, 2'd0, 2'd0, 7'd10);
    compared++;
    if (bus_if.instr_valid !== 1'b1) begin
      mismatched++; $display("FAIL pre_reset_valid: got %b required 1", bus_if.instr_valid);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({bus_if.instr_valid, halted} !== 2'b00 || err_count !== 8'd0) begin
      mismatched++;
      $display("FAIL async_flush: valid=%b halted=%b count=%0d required 0 0 0",
               bus_if.instr_valid, halted, err_count);
    end
    tick();
    reset = 1'b0;
    tick();
    compared++;
    if (bus_if.cmd_ready !== 1'b1 || bus_if.instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset: ready=%b valid=%b required 1 0",
               bus_if.cmd_ready, bus_if.instr_valid);
    end
    bus_if.instr_ready = 1'b1;
    send(3'd0, 3'd0, 2'd0, 2'd0, 7'd0);   // all-zero word is still a valid word
    compared++;
    if (bus_if.instr_valid !== 1'b1 || bus_if.instr_data !== 9'd0) begin
      mismatched++;
      $display("FAIL zero_word: valid=%b data=%b required 1 000000000",
               bus_if.instr_valid, bus_if.instr_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_move();
    test_fill();
    test_back_to_back();
    test_saturate();
    test_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
